// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the architectural program counter, reads
//   the word at pc from instruction memory over a valid/ready-style
//   handshake, holds it for decode until acknowledged, then loads the next
//   PC from the branch/next-PC logic. Retiring an HLT opcode stops fetch
//   permanently until reset.
//
//   Ports
//     clk          core clock, rising edge
//     rst_n        asynchronous active-low reset
//     pc_next      next PC from branch logic, used only on ack (bit 0 dropped)
//     imem_addr    instruction memory address (always equals pc)
//     imem_rd      read request, high while fetching
//     imem_data    instruction word from memory
//     imem_valid   memory response valid
//     pc           current program counter, bit 0 always 0
//     instr        latched instruction word
//     instr_valid  instr is presented to decode
//     instr_ack    decode consumes instr
//     halted       HLT retired, fetch stopped
//     retired      count of acknowledged instructions, wraps mod 2^16
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | one cycle after reset, no request issued
//   FETCH  | imem_rd high, waiting for imem_valid
//   HOLD   | instr_valid high, waiting for instr_ack
//   HALT   | HLT retired; everything frozen until reset

module fetch_unit #(
   parameter logic [3:0] HLT_OPC = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc_next,
   output logic [15:0] imem_addr,
   output logic        imem_rd,
   input  logic [15:0] imem_data,
   input  logic        imem_valid,
   output logic [15:0] pc,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ack,
   output logic        halted,
   output logic [15:0] retired
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0] state;

   // PC is always halfword aligned; the low bit of pc_next carries nothing.
   logic unused_pc_next_lsb;
   assign unused_pc_next_lsb = pc_next[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= 16'h0000;
         instr   <= 16'h0000;
         retired <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: state <= S_FETCH;
            S_FETCH: begin
               if (imem_valid) begin
                  instr <= imem_data;
                  state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (instr_ack) begin
                  retired <= retired + 16'd1;
                  if (instr[15:12] == HLT_OPC) begin
                     state <= S_HALT;
                  end else begin
                     pc    <= {pc_next[15:1], 1'b0};
                     state <= S_FETCH;
                  end
               end
            end
            default: state <= S_HALT;
         endcase
      end
   end

   // Handshake outputs decode straight from the registered state, so the
   // read request goes out in the same cycle FETCH is entered.
   assign imem_addr   = pc;
   assign imem_rd     = (state == S_FETCH);
   assign instr_valid = (state == S_HOLD);
   assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] pc_next;
   logic [15:0] imem_addr;
   logic        imem_rd;
   logic [15:0] imem_data;
   logic        imem_valid;
   logic [15:0] pc;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ack;
   logic        halted;
   logic [15:0] retired;

   int vectors;
   int miscompares;

   fetch_unit #(.HLT_OPC(4'hF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_next     (pc_next),
      .imem_addr   (imem_addr),
      .imem_rd     (imem_rd),
      .imem_data   (imem_data),
      .imem_valid  (imem_valid),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ack   (instr_ack),
      .halted      (halted),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        ack;
      logic [15:0] data;
      logic [15:0] pcn;
      logic        e_rd;
      logic        e_iv;
      logic        e_halt;
      logic [15:0] e_pc;
      logic [15:0] e_instr;
      logic [15:0] e_ret;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_rd, input logic e_iv,
                            input logic e_halt, input logic [15:0] e_pc,
                            input logic [15:0] e_instr, input logic [15:0] e_ret);
      check({tag, ".imem_rd"},     {15'd0, imem_rd},     {15'd0, e_rd});
      check({tag, ".instr_valid"}, {15'd0, instr_valid}, {15'd0, e_iv});
      check({tag, ".halted"},      {15'd0, halted},      {15'd0, e_halt});
      check({tag, ".pc"},          pc,                   e_pc);
      check({tag, ".imem_addr"},   imem_addr,            e_pc);
      check({tag, ".instr"},       instr,                e_instr);
      check({tag, ".retired"},     retired,              e_ret);
   endtask

   // Leaves the bench at a falling edge inside cycle 0 (the IDLE cycle).
   task automatic do_reset();
      rst_n      = 1'b0;
      imem_valid = 1'b0;
      instr_ack  = 1'b0;
      imem_data  = 16'h0000;
      pc_next    = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic v, input logic a, input logic [15:0] d, input logic [15:0] pn);
      imem_valid = v;
      instr_ack  = a;
      imem_data  = d;
      pc_next    = pn;
   endtask

   // Reference model: which phase of the instruction lifecycle we are in,
   // expressed as plain facts about the transaction, plus the architectural
   // values the spec defines.
   logic        m_started, m_have, m_halted;
   logic [15:0] m_pc, m_instr, m_ret;

   task automatic model_reset();
      m_started = 1'b0; m_have = 1'b0; m_halted = 1'b0;
      m_pc = 16'h0; m_instr = 16'h0; m_ret = 16'h0;
   endtask

   task automatic model_edge(input logic v, input logic a, input logic [15:0] d, input logic [15:0] pn);
      if (!m_started) begin
         m_started = 1'b1;
      end else if (m_halted) begin
      end else if (!m_have) begin
         if (v) begin
            m_instr = d;
            m_have  = 1'b1;
         end
      end else if (a) begin
         m_ret  = m_ret + 16'd1;
         m_have = 1'b0;
         if (m_instr[15:12] == 4'hF) m_halted = 1'b1;
         else m_pc = pn & 16'hFFFE;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      // ---- directed table: zero-wait fetch, wait states, stalled ack, HLT
      //       valid ack data      pc_next   rd   iv   h    pc        instr     ret
      tbl[0]  = '{1'b1, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b1, 1'b1, 16'hDEAD, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0000};
      tbl[3]  = '{1'b0, 1'b1, 16'h0000, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 16'h0001};
      tbl[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 16'h0001};
      tbl[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 16'h0001};
      tbl[6]  = '{1'b1, 1'b0, 16'h5A5A, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 16'h0001};
      tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h3333, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h5A5A, 16'h0001};
      tbl[8]  = '{1'b1, 1'b0, 16'hFFFF, 16'h4444, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h5A5A, 16'h0001};
      tbl[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0105, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h5A5A, 16'h0001};
      tbl[10] = '{1'b1, 1'b0, 16'hF000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0104, 16'h5A5A, 16'h0002};
      tbl[11] = '{1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0104, 16'hF000, 16'h0002};
      tbl[12] = '{1'b1, 1'b1, 16'h9999, 16'h8888, 1'b0, 1'b0, 1'b1, 16'h0104, 16'hF000, 16'h0003};

      do_reset();
      for (int k = 0; k < 13; k++) begin
         check_all($sformatf("tbl%0d", k), tbl[k].e_rd, tbl[k].e_iv, tbl[k].e_halt,
                   tbl[k].e_pc, tbl[k].e_instr, tbl[k].e_ret);
         drive(tbl[k].valid, tbl[k].ack, tbl[k].data, tbl[k].pcn);
         @(negedge clk);
      end
      // Halted core ignores all traffic for 20 cycles.
      for (int k = 0; k < 20; k++) begin
         check_all("halt_frozen", 1'b0, 1'b0, 1'b1, 16'h0104, 16'hF000, 16'h0003);
         drive(k[0], ~k[0], 16'($urandom), 16'($urandom));
         @(negedge clk);
      end

      // ---- reset in FETCH with a response pending
      do_reset();
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);                         // cycle 1: FETCH at 0
      drive(1'b1, 1'b0, 16'h2222, 16'h0);
      @(negedge clk);                         // HOLD
      drive(1'b0, 1'b1, 16'h0, 16'h0040);
      @(negedge clk);                         // FETCH at 0x40, response pending
      check_all("pre_rst", 1'b1, 1'b0, 1'b0, 16'h0040, 16'h2222, 16'h0001);
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      #2 rst_n = 1'b0;
      #1 check_all("async_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;                           // cycle 0 (IDLE): late response arrives
      drive(1'b1, 1'b0, 16'hABCD, 16'h0);
      @(negedge clk);
      check_all("late_resp", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      check_all("refetch", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

      // ---- retired wrap, starting from a forced 16'hFFFF
      do_reset();
      @(negedge clk);                         // FETCH
      force dut.retired = 16'hFFFF;
      #1 release dut.retired;
      drive(1'b1, 1'b0, 16'h1111, 16'h0);
      @(negedge clk);
      check_all("wrap_pre", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 16'hFFFF);
      drive(1'b0, 1'b1, 16'h0, 16'h0002);
      @(negedge clk);
      check_all("wrap", 1'b1, 1'b0, 1'b0, 16'h0002, 16'h1111, 16'h0000);

      // ---- randomized runs against the reference model
      for (int run = 0; run < 8; run++) begin
         do_reset();
         model_reset();
         for (int c = 0; c < 300; c++) begin
            logic        v, a;
            logic [15:0] d, pn;
            check_all("rand", m_started && !m_halted && !m_have, m_have && !m_halted,
                      m_halted, m_pc, m_instr, m_ret);
            v  = ($urandom_range(0, 2) != 0);
            a  = ($urandom_range(0, 2) != 0);
            d  = 16'($urandom);
            pn = 16'($urandom);
            if (d[15:12] == 4'hF && $urandom_range(0, 5) != 0) d[15:12] = 4'h3;
            drive(v, a, d, pn);
            model_edge(v, a, d, pn);
            @(negedge clk);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the architectural program counter. It fetches the instruction at the current PC from instruction memory through a valid/ready-style handshake and presents it to decode. It exports `pc` to the branch/next-PC logic and loads that logic's `pc_next` result when decode accepts the instruction. It also detects HLT and freezes the core.

## Interface
Parameters:
- `HLT_OPC`, default 4'hF: opcode in `instr[15:12]` that halts fetch.

Ports:
- `clk`  in  1  single core clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `pc_next`  in  16  next PC from branch/next-PC logic. Valid in any cycle where `instr_ack`=1. Bit 0 is ignored.
- `imem_addr`  out  16  instruction memory address; always equals `pc`.
- `imem_rd`  out  1  read request; high only in FETCH.
- `imem_data`  in  16  instruction word; sampled only when `imem_rd`=1 and `imem_valid`=1.
- `imem_valid`  in  1  memory response valid. May rise in the same cycle as `imem_rd` (zero-wait memory) or any later cycle.
- `pc`  out  16  current PC, registered; bit 0 always 0.
- `instr`  out  16  latched instruction, registered.
- `instr_valid`  out  1  `instr` is valid for decode.
- `instr_ack`  in  1  decode consumes `instr`; meaningful only while `instr_valid`=1.
- `halted`  out  1  HLT retired; fetch is stopped.
- `retired`  out  16  count of acknowledged instructions; wraps mod 2^16.

## Operation
- State machine with four states: IDLE, FETCH, HOLD, HALT.
- IDLE (reset state):
  - All handshake outputs low.
  - Goes to FETCH on the next clock, unconditionally.
- FETCH:
  - `imem_rd`=1, `imem_addr`=`pc`.
  - On `imem_valid`=1: `instr` <= `imem_data` and go to HOLD.
  - Otherwise stay in FETCH with `pc` held.
- HOLD:
  - `instr_valid`=1, `imem_rd`=0, `instr` stable.
  - On `instr_ack`=1, `retired` increments, then:
    - if `instr[15:12]`==`HLT_OPC`: go to HALT, `pc` unchanged;
    - otherwise: `pc` <= {`pc_next[15:1]`,1'b0} and go to FETCH.
  - With no ack, stay in HOLD and hold all outputs.
- HALT:
  - `halted`=1, `instr_valid`=0, `imem_rd`=0; `pc`, `instr` and `retired` frozen.
  - Terminal state; only `rst_n` leaves it.
- `pc_next` is used only in HOLD with ack; its value in every other cycle is ignored.
- `imem_valid` outside FETCH is ignored; a late or spurious response never overwrites `instr`.
- `retired` wraps from 16'hFFFF to 16'h0000 silently.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `pc`=16'h0000, `instr`=16'h0000, `instr_valid`=0, `imem_rd`=0, `halted`=0, `retired`=0.
  - Release is synchronous to the next `clk` edge.
- The first `imem_rd` is asserted in the cycle after the first post-reset edge.
- Throughput with zero-wait memory and immediate ack: one instruction per 2 cycles (FETCH, HOLD).
  - Each memory wait cycle adds 1 cycle.
  - Each cycle without ack adds 1 cycle.
- Register update timing:
  - `instr` is registered: visible in the cycle after `imem_valid`, coincident with `instr_valid` rising.
  - `pc` updates on the edge that samples `instr_ack`; the new `imem_addr` appears in the following FETCH cycle.
  - `halted` rises in the cycle after HLT is acked.
- Reset mid-operation, in any state including a pending memory read: immediate return to reset values. An outstanding memory response arriving afterwards is ignored, because IDLE does not sample `imem_valid`.
- `imem_valid` and `instr_ack` asserted in the same cycle: only the one relevant to the current state takes effect.
- The `pc` register is 16 bits; `pc_next` wrap-around (e.g. 16'hFFFE -> 16'h0000) is accepted as given.

## Test plan
- Reset then zero-wait memory returning 16'h1234 at address 0, ack immediate, `pc_next`=16'h0002:
  - `imem_rd` first high at cycle 1;
  - `instr_valid` high at cycle 2 with `instr`=16'h1234;
  - `imem_addr`=16'h0002 at cycle 3; `retired`=1.
- Memory with 3 wait cycles, then ack held low for 2 HOLD cycles:
  - `instr` is stable throughout;
  - `pc` changes only on the ack edge;
  - the instruction takes 7 cycles total.
- `pc_next`=16'h0105 on ack: `pc`=16'h0104 (bit 0 cleared).
- Fetch 16'hF000 and ack it:
  - `halted`=1 on the next cycle;
  - `imem_rd` stays 0 and `pc` stays frozen for 20 further cycles despite toggling `imem_valid` and `instr_ack`.
- Assert `rst_n`=0 mid-FETCH with a response pending, then deliver `imem_valid` one cycle after release:
  - all outputs return to reset values asynchronously;
  - `instr` stays 16'h0000 and the fetch restarts at address 0.
- Preload `retired` to 16'hFFFF via 65535 acks (or force it), then ack once more: `retired`=16'h0000.
